ks_voice_scheduler: RTL and testbench

- Accepts note-on/note-off events over a valid/ready handshake and allocates them across NUM_VOICES plucked-string engines.
- Per voice it drives the configuration each engine consumes: a 9-bit delay-line length, a 2-bit octave shift, a 3-bit filter select and a trig level.
- Converts note number to length/octave, picks a voice (same-note retrigger, then free, then LRU steal) and holds trig long enough for the engine's debouncer.

---
 rtl/ks_sched_pkg.sv | 47 ++++
 rtl/ks_lru_rank.sv | 53 +++++
 rtl/ks_voice_scheduler.sv | 177 +++++++++++++++++
 tb/tb_ks_voice_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_sched_pkg.sv
// Shared constants, state encoding and note-to-pitch helpers for the
// Karplus-Strong voice scheduler.
package ks_sched_pkg;

    localparam int LEN_W  = 9;
    localparam int OCT_W  = 2;
    localparam int FILT_W = 3;
    localparam int NOTE_W = 7;

    // Delay-line length per pitch class: round(480 * 2^(-pc/12)).
    localparam logic [LEN_W-1:0] LEN_TABLE [12] = '{
        9'd480, 9'd453, 9'd428, 9'd404, 9'd381, 9'd360,
        9'd339, 9'd320, 9'd302, 9'd285, 9'd269, 9'd254
    };

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIV    = 3'd1,
        SEARCH = 3'd2,
        ALLOC  = 3'd3,
        FIRE   = 3'd4,
        GAP    = 3'd5
    } sched_state_t;

    function automatic logic [LEN_W-1:0] len_lookup(input logic [3:0] pc);
        logic [LEN_W-1:0] len;
        if (pc < 4'd12) begin
            len = LEN_TABLE[pc];
        end else begin
            len = LEN_TABLE[0];
        end
        return len;
    endfunction

    // Engines only span four octaves, so the raw quotient is clamped.
    function automatic logic [OCT_W-1:0] octave_sat(input logic [3:0] oct_raw);
        logic [OCT_W-1:0] oct;
        case (oct_raw)
            4'd0, 4'd1, 4'd2, 4'd3: oct = 2'd0;
            4'd4:                   oct = 2'd1;
            4'd5:                   oct = 2'd2;
            default:                oct = 2'd3;
        endcase
        return oct;
    endfunction

endpackage

// File: rtl/ks_lru_rank.sv
// Least-recently-used ranking of voices; rank 0 is newest, rank NUM_VOICES-1
// is the steal candidate reported on oldest_idx.
module ks_lru_rank #(
    parameter int NUM_VOICES = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          upd_en,
    input  logic [$clog2(NUM_VOICES)-1:0] upd_idx,
    output logic [$clog2(NUM_VOICES)-1:0] oldest_idx
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    logic [IDX_W-1:0] rank_r      [NUM_VOICES];
    logic [IDX_W-1:0] rank_next_s [NUM_VOICES];
    logic [IDX_W-1:0] oldest_next_s;

    // Next-rank computation: promote the used voice, age the ones it overtook.
    always_comb begin
        oldest_next_s = oldest_idx;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!upd_en) begin
                rank_next_s[i] = rank_r[i];
            end else if (IDX_W'(i) == upd_idx) begin
                rank_next_s[i] = '0;
            end else if (rank_r[i] < rank_r[upd_idx]) begin
                rank_next_s[i] = rank_r[i] + IDX_W'(1);
            end else begin
                rank_next_s[i] = rank_r[i];
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            oldest_next_s = (rank_next_s[i] == IDX_W'(NUM_VOICES - 1)) ? IDX_W'(i) : oldest_next_s;
        end
    end

    // Rank and oldest-voice registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_r[i] <= IDX_W'(i);
            end
            oldest_idx <= IDX_W'(NUM_VOICES - 1);
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_r[i] <= rank_next_s[i];
            end
            oldest_idx <= oldest_next_s;
        end
    end

endmodule

// File: rtl/ks_voice_scheduler.sv
// Note event allocator for NUM_VOICES plucked-string engines: converts notes
// to delay length/octave, picks a voice and paces the pluck trigger.
module ks_voice_scheduler
    import ks_sched_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int TRIG_HOLD  = 16,
    parameter int TRIG_GAP   = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           note_valid,
    output logic                           note_ready,
    input  logic                           note_on,
    input  logic [NOTE_W-1:0]              note_num,
    input  logic [FILT_W-1:0]              note_filtsw,
    output logic [NUM_VOICES-1:0]          voice_trig,
    output logic [NUM_VOICES*LEN_W-1:0]    voice_len,
    output logic [NUM_VOICES*OCT_W-1:0]    voice_octave,
    output logic [NUM_VOICES*FILT_W-1:0]   voice_filtsw,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic                           steal_evt
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    sched_state_t      state_r;
    logic              on_r;
    logic [NOTE_W-1:0] note_r;
    logic [FILT_W-1:0] filt_r;
    logic [NOTE_W-1:0] rem_r;
    logic [3:0]        oct_raw_r;
    logic [IDX_W-1:0]  target_r;
    logic [15:0]       cnt_r;
    logic [NOTE_W-1:0] note_mem_r [NUM_VOICES];

    logic              match_hit_s;
    logic [IDX_W-1:0]  match_idx_s;
    logic              free_hit_s;
    logic [IDX_W-1:0]  free_idx_s;
    logic [IDX_W-1:0]  target_s;
    logic              steal_s;
    logic [IDX_W-1:0]  oldest_s;
    logic              lru_upd_s;

    assign lru_upd_s = (state_r == SEARCH) && on_r;

    ks_lru_rank #(.NUM_VOICES(NUM_VOICES)) u_lru (
        .clk        (clk),
        .reset_n    (reset_n),
        .upd_en     (lru_upd_s),
        .upd_idx    (target_s),
        .oldest_idx (oldest_s)
    );

    // Voice selection; scanning downward leaves the lowest matching index.
    always_comb begin
        match_hit_s = 1'b0;
        match_idx_s = '0;
        free_hit_s  = 1'b0;
        free_idx_s  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            match_idx_s = (voice_active[i] && (note_mem_r[i] == note_r)) ? IDX_W'(i) : match_idx_s;
            match_hit_s = (voice_active[i] && (note_mem_r[i] == note_r)) ? 1'b1 : match_hit_s;
            free_idx_s  = (!voice_active[i]) ? IDX_W'(i) : free_idx_s;
            free_hit_s  = (!voice_active[i]) ? 1'b1 : free_hit_s;
        end
        if (match_hit_s) begin
            target_s = match_idx_s;
            steal_s  = 1'b0;
        end else if (free_hit_s) begin
            target_s = free_idx_s;
            steal_s  = 1'b0;
        end else begin
            target_s = oldest_s;
            steal_s  = 1'b1;
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            on_r         <= 1'b0;
            note_r       <= '0;
            filt_r       <= '0;
            rem_r        <= '0;
            oct_raw_r    <= 4'd0;
            target_r     <= '0;
            cnt_r        <= 16'd0;
            note_ready   <= 1'b1;
            voice_trig   <= '0;
            voice_len    <= '0;
            voice_octave <= '0;
            voice_filtsw <= '0;
            voice_active <= '0;
            steal_evt    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_mem_r[i] <= '0;
            end
        end else begin
            steal_evt <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (note_valid && note_ready) begin
                        on_r       <= note_on;
                        note_r     <= note_num;
                        filt_r     <= note_filtsw;
                        rem_r      <= note_num;
                        oct_raw_r  <= 4'd0;
                        note_ready <= 1'b0;
                        state_r    <= DIV;
                    end
                end
                DIV: begin
                    if (rem_r >= 7'd12) begin
                        rem_r     <= rem_r - 7'd12;
                        oct_raw_r <= oct_raw_r + 4'd1;
                    end else begin
                        state_r <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (on_r) begin
                        // Config lands now so it leads the trigger by a cycle.
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == target_s) begin
                                voice_len[LEN_W*i +: LEN_W]     <= len_lookup(rem_r[3:0]);
                                voice_octave[OCT_W*i +: OCT_W]  <= octave_sat(oct_raw_r);
                                voice_filtsw[FILT_W*i +: FILT_W] <= filt_r;
                                note_mem_r[i]                   <= note_r;
                                voice_active[i]                 <= 1'b1;
                            end
                        end
                        target_r  <= target_s;
                        steal_evt <= steal_s;
                        state_r   <= ALLOC;
                    end else begin
                        if (match_hit_s) begin
                            voice_active[match_idx_s] <= 1'b0;
                        end
                        note_ready <= 1'b1;
                        state_r    <= IDLE;
                    end
                end
                ALLOC: begin
                    voice_trig[target_r] <= 1'b1;
                    cnt_r                <= 16'd0;
                    state_r              <= FIRE;
                end
                FIRE: begin
                    if (cnt_r == 16'(TRIG_HOLD - 1)) begin
                        voice_trig <= '0;
                        cnt_r      <= 16'd0;
                        state_r    <= GAP;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt_r == 16'(TRIG_GAP - 1)) begin
                        note_ready <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    voice_trig <= '0;
                    note_ready <= 1'b1;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ks_voice_scheduler.sv
// Randomised self-checking bench for ks_voice_scheduler against a list-based
// voice allocation model.
module tb_ks_voice_scheduler;

    localparam int NV   = 4;
    localparam int HOLD = 16;
    localparam int GAPC = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            note_valid = 1'b0;
    logic            note_on = 1'b0;
    logic [6:0]      note_num = 7'd0;
    logic [2:0]      note_filtsw = 3'd0;
    logic            note_ready;
    logic [NV-1:0]   voice_trig;
    logic [NV*9-1:0] voice_len;
    logic [NV*2-1:0] voice_octave;
    logic [NV*3-1:0] voice_filtsw;
    logic [NV-1:0]   voice_active;
    logic            steal_evt;

    int n_cmp = 0;
    int n_bad = 0;

    int len_ref [12] = '{480, 453, 428, 404, 381, 360, 339, 320, 302, 285, 269, 254};
    int m_lru [$];
    bit m_act [NV];
    int m_note [NV];
    int m_len [NV];
    int m_oct [NV];
    int m_filt [NV];

    always #5 clk = ~clk;

    ks_voice_scheduler #(.NUM_VOICES(NV), .TRIG_HOLD(HOLD), .TRIG_GAP(GAPC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .note_valid   (note_valid),
        .note_ready   (note_ready),
        .note_on      (note_on),
        .note_num     (note_num),
        .note_filtsw  (note_filtsw),
        .voice_trig   (voice_trig),
        .voice_len    (voice_len),
        .voice_octave (voice_octave),
        .voice_filtsw (voice_filtsw),
        .voice_active (voice_active),
        .steal_evt    (steal_evt)
    );

    function automatic int exp_oct(input int n);
        int q = n / 12;
        return (q <= 3) ? 0 : ((q >= 6) ? 3 : q - 3);
    endfunction

    function automatic void model_reset();
        m_lru.delete();
        for (int i = 0; i < NV; i++) begin
            m_lru.push_back(i);
            m_act[i] = 1'b0; m_note[i] = 0; m_len[i] = 0; m_oct[i] = 0; m_filt[i] = 0;
        end
    endfunction

    // Model of a note-on: returns the chosen voice and whether it was a steal.
    function automatic void model_on(input int n, input int f, output int v, output int st);
        v = -1; st = 0;
        for (int i = 0; i < NV; i++) if (v < 0 && m_act[i] && m_note[i] == n) v = i;
        for (int i = 0; i < NV; i++) if (v < 0 && !m_act[i]) v = i;
        if (v < 0) begin v = m_lru[$]; st = 1; end
        m_act[v] = 1'b1; m_note[v] = n; m_len[v] = len_ref[n % 12];
        m_oct[v] = exp_oct(n); m_filt[v] = f;
        for (int k = 0; k < m_lru.size(); k++) if (m_lru[k] == v) begin m_lru.delete(k); break; end
        m_lru.push_front(v);
    endfunction

    function automatic void model_off(input int n);
        for (int i = 0; i < NV; i++) if (m_act[i] && m_note[i] == n) begin m_act[i] = 1'b0; break; end
    endfunction

    function automatic logic [NV*9-1:0] exp_len_vec();
        logic [NV*9-1:0] v;
        for (int i = 0; i < NV; i++) v[9*i +: 9] = 9'(m_len[i]);
        return v;
    endfunction

    function automatic logic [NV-1:0] exp_act_vec();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_act[i];
        return v;
    endfunction

    // Number of voice fields disagreeing with the model.
    function automatic int voice_diff();
        int d = 0;
        for (int i = 0; i < NV; i++) begin
            if (int'(voice_len[9*i +: 9]) != m_len[i]) d++;
            if (int'(voice_octave[2*i +: 2]) != m_oct[i]) d++;
            if (int'(voice_filtsw[3*i +: 3]) != m_filt[i]) d++;
            if (voice_active[i] != m_act[i]) d++;
        end
        return d;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Issues one event and measures the response relative to the transfer edge.
    task automatic do_event(input bit on, input int num, input int filt,
                            output int lat, output int tw, output int tv, output int st,
                            output int rl, output logic [NV*9-1:0] pre_len);
        int k = 0;
        logic [NV*9-1:0] prev_len;
        lat = -1; tw = 0; tv = -1; st = 0; rl = -1; pre_len = '0;
        while (!note_ready && k < 200) begin @(negedge clk); k++; end
        note_valid = 1'b1; note_on = on; note_num = 7'(num); note_filtsw = 3'(filt);
        @(posedge clk); #1;
        note_valid = 1'b0;
        prev_len = voice_len;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (voice_trig != '0) begin
                tw++;
                if (lat < 0) begin
                    lat = c; pre_len = prev_len;
                    for (int i = 0; i < NV; i++) if (voice_trig[i]) tv = (tv == -1) ? i : -2;
                end
            end
            st += int'(steal_evt);
            prev_len = voice_len;
            if (note_ready) begin rl = c; break; end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (note_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", note_ready); end
        n_cmp++; if (voice_trig !== '0) begin n_bad++; $display("FAIL reset_trig got %b want 0", voice_trig); end
        n_cmp++; if (voice_active !== '0) begin n_bad++; $display("FAIL reset_active got %b want 0", voice_active); end
        n_cmp++; if ({voice_len, voice_octave, voice_filtsw, steal_evt} !== '0) begin
            n_bad++; $display("FAIL reset_cfg got len=%h oct=%h filt=%h steal=%b want all 0", voice_len, voice_octave, voice_filtsw, steal_evt);
        end
    endtask

    task automatic test_first_note();
        int ev, es, lat, tw, tv, st, rl;
        logic [NV*9-1:0] pl;
        model_on(60, 2, ev, es);
        do_event(1'b1, 60, 2, lat, tw, tv, st, rl, pl);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL first_latency got %0d want 8", lat); end
        n_cmp++; if (tw !== HOLD) begin n_bad++; $display("FAIL first_trig_width got %0d want %0d", tw, HOLD); end
        n_cmp++; if (tv !== 0 || ev !== 0) begin n_bad++; $display("FAIL first_voice got %0d want 0", tv); end
        n_cmp++; if (rl !== 8 + HOLD + GAPC) begin n_bad++; $display("FAIL first_ready got %0d want %0d", rl, 8 + HOLD + GAPC); end
        n_cmp++; if (voice_len[8:0] !== 9'd480 || voice_octave[1:0] !== 2'd2 || voice_filtsw[2:0] !== 3'd2) begin
            n_bad++; $display("FAIL first_cfg got len=%0d oct=%0d filt=%0d want 480/2/2", voice_len[8:0], voice_octave[1:0], voice_filtsw[2:0]);
        end
        n_cmp++; if (voice_active !== 4'b0001) begin n_bad++; $display("FAIL first_active got %b want 0001", voice_active); end
        n_cmp++; if (pl !== exp_len_vec()) begin n_bad++; $display("FAIL first_cfg_lead got %h want %h", pl, exp_len_vec()); end
        n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL first_steal got %0d want 0", st); end
    endtask

    task automatic test_alloc_sequence();
        int notes [3] = '{69, 21, 127};
        int ev, es, lat, tw, tv, st, rl;
        logic [NV*9-1:0] pl;
        for (int j = 0; j < 3; j++) begin
            model_on(notes[j], j + 3, ev, es);
            do_event(1'b1, notes[j], j + 3, lat, tw, tv, st, rl, pl);
            n_cmp++; if (tv !== ev || lat !== notes[j] / 12 + 3) begin
                n_bad++; $display("FAIL alloc_voice note %0d got voice %0d lat %0d want voice %0d lat %0d", notes[j], tv, lat, ev, notes[j] / 12 + 3);
            end
            n_cmp++; if (voice_diff() !== 0) begin
                n_bad++; $display("FAIL alloc_cfg note %0d got len=%h act=%b want len=%h act=%b", notes[j], voice_len, voice_active, exp_len_vec(), exp_act_vec());
            end
        end
    endtask

    task automatic test_retrigger();
        int ev, es, lat, tw, tv, st, rl;
        logic [NV*9-1:0] pl;
        model_on(60, 7, ev, es);
        do_event(1'b1, 60, 7, lat, tw, tv, st, rl, pl);
        n_cmp++; if (tv !== 0 || tw !== HOLD) begin n_bad++; $display("FAIL retrig_voice got %0d width %0d want 0 width %0d", tv, tw, HOLD); end
        n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL retrig_steal got %0d want 0", st); end
        n_cmp++; if (voice_active !== exp_act_vec() || voice_diff() !== 0) begin
            n_bad++; $display("FAIL retrig_cfg got act=%b want %b", voice_active, exp_act_vec());
        end
    endtask

    task automatic test_steal();
        int ev, es, lat, tw, tv, st, rl;
        logic [NV*9-1:0] pl;
        apply_reset();
        for (int n = 40; n <= 45; n++) begin
            model_on(n, n % 8, ev, es);
            do_event(1'b1, n, n % 8, lat, tw, tv, st, rl, pl);
            n_cmp++; if (tv !== ev || st !== es) begin
                n_bad++; $display("FAIL steal_pick note %0d got voice %0d steals %0d want voice %0d steals %0d", n, tv, st, ev, es);
            end
        end
        n_cmp++; if (voice_len[8:0] !== 9'(len_ref[44 % 12]) || voice_len[17:9] !== 9'(len_ref[45 % 12])) begin
            n_bad++; $display("FAIL steal_len got %0d/%0d want %0d/%0d", voice_len[8:0], voice_len[17:9], len_ref[44 % 12], len_ref[45 % 12]);
        end
        n_cmp++; if (voice_diff() !== 0) begin n_bad++; $display("FAIL steal_cfg got act=%b len=%h want act=%b len=%h", voice_active, voice_len, exp_act_vec(), exp_len_vec()); end
    endtask

    task automatic test_note_off();
        int lat, tw, tv, st, rl;
        logic [NV*9-1:0] pl;
        model_off(42);
        do_event(1'b0, 42, 0, lat, tw, tv, st, rl, pl);
        n_cmp++; if (tw !== 0 || st !== 0) begin n_bad++; $display("FAIL off_quiet got trig %0d steal %0d want 0/0", tw, st); end
        n_cmp++; if (voice_active !== exp_act_vec() || voice_active[2] !== 1'b0) begin
            n_bad++; $display("FAIL off_active got %b want %b", voice_active, exp_act_vec());
        end
        model_off(99);
        do_event(1'b0, 99, 0, lat, tw, tv, st, rl, pl);
        n_cmp++; if (voice_diff() !== 0 || tw !== 0) begin n_bad++; $display("FAIL off_nomatch got act=%b trig %0d want act=%b trig 0", voice_active, tw, exp_act_vec()); end
        n_cmp++; if (rl < 99 / 12 + 2 || rl > 99 / 12 + 3) begin n_bad++; $display("FAIL off_ready got %0d want %0d..%0d", rl, 99 / 12 + 2, 99 / 12 + 3); end
    endtask

    task automatic test_random();
        int ev, es, lat, tw, tv, st, rl, n, f;
        bit on;
        logic [NV*9-1:0] pl;
        for (int j = 0; j < 30; j++) begin
            on = ($urandom_range(0, 9) < 6);
            n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : 36 + int'($urandom_range(0, 7));
            f  = int'($urandom_range(0, 7));
            if (on) begin
                model_on(n, f, ev, es);
                do_event(1'b1, n, f, lat, tw, tv, st, rl, pl);
                n_cmp++; if (tv !== ev || st !== es || lat !== n / 12 + 3 || tw !== HOLD || rl !== lat + HOLD + GAPC) begin
                    n_bad++; $display("FAIL rand_on note %0d got v=%0d st=%0d lat=%0d w=%0d rdy=%0d want v=%0d st=%0d lat=%0d w=%0d",
                                      n, tv, st, lat, tw, rl, ev, es, n / 12 + 3, HOLD);
                end
                n_cmp++; if (pl !== exp_len_vec()) begin n_bad++; $display("FAIL rand_cfg_lead note %0d got %h want %h", n, pl, exp_len_vec()); end
            end else begin
                model_off(n);
                do_event(1'b0, n, f, lat, tw, tv, st, rl, pl);
                n_cmp++; if (tw !== 0 || st !== 0 || rl < n / 12 + 2 || rl > n / 12 + 3) begin
                    n_bad++; $display("FAIL rand_off note %0d got w=%0d st=%0d rdy=%0d want 0/0/%0d..%0d", n, tw, st, rl, n / 12 + 2, n / 12 + 3);
                end
            end
            n_cmp++; if (voice_diff() !== 0) begin
                n_bad++; $display("FAIL rand_state ev %0d got act=%b len=%h want act=%b len=%h", j, voice_active, voice_len, exp_act_vec(), exp_len_vec());
            end
        end
    endtask

    task automatic test_reset_mid_fire();
        int k = 0;
        @(negedge clk);
        while (!note_ready && k < 200) begin @(negedge clk); k++; end
        note_valid = 1'b1; note_on = 1'b1; note_num = 7'd50; note_filtsw = 3'd5;
        @(posedge clk); #1;
        note_valid = 1'b0;
        k = 0;
        while (voice_trig == '0 && k < 50) begin @(posedge clk); #1; k++; end
        n_cmp++; if (voice_trig == '0) begin n_bad++; $display("FAIL midfire_trig got %b want nonzero", voice_trig); end
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (voice_trig !== '0 || voice_active !== '0 || steal_evt !== 1'b0) begin
            n_bad++; $display("FAIL midfire_async got trig=%b act=%b steal=%b want 0/0/0", voice_trig, voice_active, steal_evt);
        end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_cmp++; if (note_ready !== 1'b1 || voice_len !== '0) begin n_bad++; $display("FAIL midfire_release got ready=%b len=%h want 1/0", note_ready, voice_len); end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_alloc_sequence();
        test_retrigger();
        test_steal();
        test_note_off();
        test_random();
        test_reset_mid_fire();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
